input_debouncer: RTL and testbench

Cleans a raw, asynchronous, bouncing single-bit input, such as a push-button or switch, before it reaches the combinational gate stages, for example `NOT_gate`. The block has three parts:
- a two-flop synchronizer on the raw input;
- a four-state debounce FSM with a stability counter;
- registered outputs: a clean level and one-cycle rise/fall pulses.

Its `y` output drives the `a` input of the downstream gate directly.

---
 rtl/input_debouncer_if.sv | 25 ++
 rtl/input_debouncer.sv | 125 ++++++++++++
 tb/tb_input_debouncer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// input_debouncer_if: raw input and cleaned outputs of the debouncer.
// master drives the raw input; slave is the debouncer itself.
interface input_debouncer_if;
    logic a_raw;
    logic y;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output a_raw,
        input  y,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  a_raw,
        output y,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchronizer feeding a four-state debounce FSM.
// Level y flips only after STABLE_CYCLES consecutive differing samples.
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 8
) (
    input logic         clk,
    input logic         rst,
    input_debouncer_if.slave bus
);
    localparam int W = $clog2(STABLE_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(STABLE_CYCLES - 1);
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        IDLE_LOW,
        CHK_HIGH,
        IDLE_HIGH,
        CHK_LOW
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         s1;
    logic         s2;
    logic         rise_q;
    logic         fall_q;
    logic         rise_nxt;
    logic         fall_nxt;

    // Synchronize the raw input; only s2 is trusted by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.a_raw;
            s2 <= s1;
        end
    end

    // State, stability counter and registered edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE_LOW;
            cnt    <= ZERO;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
        end
    end

    // Next state: qualify a candidate level, restart from idle on any revert.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        unique case (state)
            IDLE_LOW: begin
                cnt_nxt = ZERO;
                if (s2) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nxt = IDLE_HIGH;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = CHK_HIGH;
                        cnt_nxt   = ONE;
                    end
                end
            end
            CHK_HIGH: begin
                if (!s2) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = ZERO;
                end else if (cnt == LAST) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = ZERO;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            IDLE_HIGH: begin
                cnt_nxt = ZERO;
                if (!s2) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nxt = IDLE_LOW;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = CHK_LOW;
                        cnt_nxt   = ONE;
                    end
                end
            end
            CHK_LOW: begin
                if (s2) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = ZERO;
                end else if (cnt == LAST) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = ZERO;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = ZERO;
            end
        endcase
    end

    assign bus.y    = (state == IDLE_HIGH) || (state == CHK_LOW);
    assign bus.busy = (state == CHK_HIGH) || (state == CHK_LOW);
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: scoreboard bench for the debouncer.
// A run-length reference model queues expected outputs per edge.
module tb_input_debouncer;
    localparam int SC = 8;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    input_debouncer_if bus ();
    input_debouncer_if bus1 ();

    input_debouncer #(.STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    input_debouncer #(.STABLE_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: sync pipe, level, run of differing samples.
    logic       ms1;
    logic       ms2;
    logic       my;
    int         mrun;
    logic [3:0] sb_q[$];

    // Advance the model by one edge and queue {y, rise, fall, busy}.
    task automatic model(input logic a, input logic r);
        logic er;
        logic ef;
        er = 1'b0;
        ef = 1'b0;
        if (r) begin
            ms1  = 1'b0;
            ms2  = 1'b0;
            my   = 1'b0;
            mrun = 0;
        end else begin
            if (ms2 != my) begin
                if (mrun + 1 >= SC) begin
                    my   = ms2;
                    er   = ms2;
                    ef   = !ms2;
                    mrun = 0;
                end else begin
                    mrun = mrun + 1;
                end
            end else begin
                mrun = 0;
            end
            ms2 = ms1;
            ms1 = a;
        end
        sb_q.push_back({my, er, ef, (mrun != 0)});
    endtask

    // Drive one edge's worth of stimulus, then sample 1 ns after the edge.
    task automatic tick(input logic a, input logic r);
        bus.a_raw  = a;
        bus1.a_raw = a;
        rst        = r;
        model(a, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] exp;
        logic [3:0] got;
        int         t_rise;
        for (int e = 0; e < 3; e++) begin
            tick(1'b1, 1'b1);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp || got !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset e%0d got %b want %b", e, got, exp);
            end
        end
        t_rise = -1;
        for (int e = 0; e < 14; e++) begin
            tick(1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_rel e%0d got %b want %b", e, got, exp);
            end
            if (bus.rise === 1'b1 && t_rise < 0) t_rise = e;
        end
        vectors++;
        if (t_rise !== SC + 1) begin
            miscompares++;
            $display("FAIL reset_rise_edge got %0d want %0d", t_rise, SC + 1);
        end
    endtask

    task automatic test_clean_fall;
        logic [3:0] exp;
        logic [3:0] got;
        int         t_fall;
        int         n_rise;
        t_fall = -1;
        n_rise = 0;
        for (int e = 0; e < 14; e++) begin
            tick(1'b0, 1'b0);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL clean_fall e%0d got %b want %b", e, got, exp);
            end
            if (bus.fall === 1'b1 && t_fall < 0) t_fall = e;
            if (bus.rise === 1'b1) n_rise++;
        end
        vectors++;
        if (t_fall !== SC + 1 || n_rise !== 0) begin
            miscompares++;
            $display("FAIL fall_edge got %0d/%0d want %0d/0",
                     t_fall, n_rise, SC + 1);
        end
    endtask

    task automatic test_glitch;
        logic [3:0] exp;
        logic [3:0] got;
        int         saw_busy;
        int         n_rise;
        saw_busy = 0;
        n_rise   = 0;
        for (int e = 0; e < 14; e++) begin
            tick((e < 5) ? 1'b1 : 1'b0, 1'b0);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL glitch e%0d got %b want %b", e, got, exp);
            end
            if (bus.busy === 1'b1) saw_busy = 1;
            if (bus.rise === 1'b1) n_rise++;
        end
        vectors++;
        if (saw_busy !== 1 || n_rise !== 0 || bus.y !== 1'b0 ||
            dut.cnt !== '0) begin
            miscompares++;
            $display("FAIL glitch_end got busy%0d rise%0d y%b cnt%0d want 1 0 0 0",
                     saw_busy, n_rise, bus.y, dut.cnt);
        end
    endtask

    task automatic test_bounce;
        logic [3:0] exp;
        logic [3:0] got;
        logic [4:0] pat;
        int         t_rise;
        int         n_rise;
        pat    = 5'b10101;
        t_rise = -1;
        n_rise = 0;
        for (int e = 0; e < 20; e++) begin
            tick((e < 5) ? pat[4 - e] : 1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL bounce e%0d got %b want %b", e, got, exp);
            end
            if (bus.rise === 1'b1) begin
                n_rise++;
                if (t_rise < 0) t_rise = e;
            end
        end
        vectors++;
        if (n_rise !== 1 || t_rise !== 4 + SC + 1 || bus.y !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_rise got n%0d e%0d y%b want n1 e%0d y1",
                     n_rise, t_rise, bus.y, 4 + SC + 1);
        end
    endtask

    task automatic test_reset_mid_check;
        logic [3:0] exp;
        logic [3:0] got;
        int         t_rise;
        tick(1'b1, 1'b1);
        exp = sb_q.pop_front();
        got = {bus.y, bus.rise, bus.fall, bus.busy};
        vectors++;
        if (got !== exp || got !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_from_high got %b want %b", got, exp);
        end
        for (int e = 0; e < 7; e++) begin
            tick(1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL mid_pre e%0d got %b want %b", e, got, exp);
            end
        end
        vectors++;
        if (dut.cnt !== 4'd5 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_cnt got cnt%0d busy%b want cnt5 busy1",
                     dut.cnt, bus.busy);
        end
        tick(1'b1, 1'b1);
        exp = sb_q.pop_front();
        got = {bus.y, bus.rise, bus.fall, bus.busy};
        vectors++;
        if (got !== exp || got !== 4'b0000 || dut.cnt !== '0) begin
            miscompares++;
            $display("FAIL mid_abort got %b cnt%0d want %b cnt0",
                     got, dut.cnt, exp);
        end
        t_rise = -1;
        for (int e = 0; e < 14; e++) begin
            tick(1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL mid_requal e%0d got %b want %b", e, got, exp);
            end
            if (bus.rise === 1'b1 && t_rise < 0) t_rise = e;
        end
        vectors++;
        if (t_rise !== SC + 1) begin
            miscompares++;
            $display("FAIL mid_rise_edge got %0d want %0d", t_rise, SC + 1);
        end
    endtask

    task automatic test_revert_edge;
        logic [3:0] exp;
        logic [3:0] got;
        int         n_fall;
        int         t_fall;
        n_fall = 0;
        for (int e = 0; e < 16; e++) begin
            tick((e < SC - 1) ? 1'b0 : 1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL revert e%0d got %b want %b", e, got, exp);
            end
            if (bus.fall === 1'b1) n_fall++;
        end
        vectors++;
        if (n_fall !== 0 || bus.y !== 1'b1) begin
            miscompares++;
            $display("FAIL revert_nofall got n%0d y%b want n0 y1",
                     n_fall, bus.y);
        end
        t_fall = -1;
        for (int e = 0; e < 14; e++) begin
            tick((e < SC) ? 1'b0 : 1'b1, 1'b0);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL exact e%0d got %b want %b", e, got, exp);
            end
            if (bus.fall === 1'b1 && t_fall < 0) t_fall = e;
        end
        for (int e = 0; e < 14; e++) begin
            tick(1'b0, 1'b0);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL exact_hold e%0d got %b want %b", e, got, exp);
            end
        end
        vectors++;
        if (t_fall !== SC + 1 || bus.y !== 1'b0) begin
            miscompares++;
            $display("FAIL exact_fall got e%0d y%b want e%0d y0",
                     t_fall, bus.y, SC + 1);
        end
    endtask

    task automatic test_clean_rise;
        logic [3:0] exp;
        logic [3:0] got;
        logic [3:0] want;
        for (int e = 0; e < 14; e++) begin
            tick(1'b1, 1'b0);
            exp  = sb_q.pop_front();
            got  = {bus.y, bus.rise, bus.fall, bus.busy};
            want = {(e >= SC + 1), (e == SC + 1), 1'b0,
                    (e >= 2 && e <= SC)};
            vectors++;
            if (got !== exp || got !== want) begin
                miscompares++;
                $display("FAIL clean_rise e%0d got %b want %b/%b",
                         e, got, exp, want);
            end
        end
    endtask

    task automatic test_single_cycle;
        logic [3:0] exp;
        logic [3:0] got;
        logic [3:0] want;
        tick(1'b0, 1'b1);
        exp = sb_q.pop_front();
        for (int e = 0; e < 3; e++) begin
            tick(1'b0, 1'b0);
            exp = sb_q.pop_front();
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL sc1_main e%0d got %b want %b", e, got, exp);
            end
        end
        for (int e = 0; e < 8; e++) begin
            tick((e < 4) ? 1'b1 : 1'b0, 1'b0);
            exp = sb_q.pop_front();
            got = {bus1.y, bus1.rise, bus1.fall, bus1.busy};
            if (e < 4)
                want = {(e >= 2), (e == 2), 1'b0, 1'b0};
            else
                want = {(e < 6), 1'b0, (e == 6), 1'b0};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL sc1 e%0d got %b want %b", e, got, want);
            end
            got = {bus.y, bus.rise, bus.fall, bus.busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL sc1_main e%0d got %b want %b", e, got, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ms1         = 1'b0;
        ms2         = 1'b0;
        my          = 1'b0;
        mrun        = 0;
        rst         = 1'b1;
        bus.a_raw   = 1'b0;
        bus1.a_raw  = 1'b0;
        test_reset();
        test_clean_fall();
        test_glitch();
        test_bounce();
        test_reset_mid_check();
        test_revert_edge();
        test_clean_rise();
        test_single_cycle();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
